bp_update_sched: RTL and testbench
==================================

Name: bp_update_sched

Overview:
- Sequences the write port of the gshare pattern-history table (PHT) and owns the global history register (GHR).
- After reset, or on request, walks every PHT index and writes each entry to weakly-taken (2'b10).
- In normal operation, accepts up to two resolved branches per cycle from the two EX lanes and computes each gshare index in program order. Buffers them in a small FIFO and drains one PHT update per cycle.
- Sits between the EX-stage branch-resolve logic and the predictor table.

Parameters:
- PC_W, 14, width of branch PC presented by EX lanes
- IDX_W, 12, PHT index width (table depth = 2**IDX_W)
- GHR_W, 12, global history length; must be <= IDX_W
- QDEPTH, 4, update FIFO entries; power of two, >= 2

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- reinit  in  1  pulse: restart table initialisation
- upd_valid_0  in  1  lane 0 (older) branch resolved
- upd_pc_0  in  PC_W  lane 0 branch PC
- upd_taken_0  in  1  lane 0 outcome
- upd_valid_1  in  1  lane 1 (younger) branch resolved
- upd_pc_1  in  PC_W  lane 1 branch PC
- upd_taken_1  in  1  lane 1 outcome
- upd_ready  out  1  both lanes may transfer this cycle
- pht_we  out  1  PHT write strobe (registered)
- pht_widx  out  IDX_W  PHT write index (registered)
- pht_wtaken  out  1  outcome for saturating-counter update (registered)
- pht_winit  out  1  force entry to 2'b10, ignore pht_wtaken (registered)
- ghr  out  GHR_W  current committed history, to fetch-side index hash
- init_busy  out  1  initialisation walk in progress
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock clk; reset rst is asynchronous and active-low.
- Reset values: state=INIT, init_cnt=0, FIFO empty, ghr=0.
  - Registered outputs reset to 0: pht_we, pht_widx, pht_wtaken, pht_winit.
  - init_busy=1 and upd_ready=0 during reset.
- State INIT:
  - Each cycle, register pht_we=1, pht_winit=1, pht_widx=init_cnt, pht_wtaken=0, then increment init_cnt.
  - Index k is presented on the outputs in cycle k+1 after rst deasserts.
  - When init_cnt == 2**IDX_W-1 is issued, go to RUN. init_cnt wraps to 0.
  - While in INIT: upd_ready=0, init_busy=1, and incoming valids are ignored.
- State RUN:
  - init_busy=0.
  - upd_ready = (QDEPTH - q_count) >= 2, using occupancy at cycle start. A same-cycle dequeue is not credited.
- Transfer: lane n transfers when upd_valid_n && upd_ready. Lane 1 valid without lane 0 is legal and treated as a single branch.
- Index hash, in program order:
  - idx0 = upd_pc_0[IDX_W+1:2] ^ zero-extended ghr.
  - g1 = lane 0 transferred ? {ghr[GHR_W-2:0], upd_taken_0} : ghr.
  - idx1 = upd_pc_1[IDX_W+1:2] ^ zero-extended g1.
  - Next ghr = lane 1 transferred ? {g1[GHR_W-2:0], upd_taken_1} : g1.
  - Lane 0 is enqueued before lane 1.
- Dequeue: in RUN with q_count>0, pop the head each cycle and register pht_we=1, pht_winit=0, pht_widx=head.idx, pht_wtaken=head.taken. Otherwise register pht_we=0.
- Latency: a branch accepted at edge N into an empty FIFO appears on the pht_* outputs after edge N+1.
  - Two branches accepted together: lane 0 write at N+1, lane 1 write at N+2.
- Simultaneous enqueue and dequeue: allowed. q_count += enq_count - deq.
- Wrap-around: read/write pointers are log2(QDEPTH) bits and wrap naturally. Full/empty is derived from q_count.
- reinit in RUN:
  - Next cycle: state=INIT, init_cnt=0, FIFO flushed (pending updates dropped), ghr=0.
  - Any same-cycle transfers are discarded and do not shift ghr. The dequeue in that cycle is also suppressed, so pht_we=0 next cycle.
- reinit in INIT: restarts the walk at 0.
- Asynchronous reset mid-walk or mid-drain: all state returns immediately to reset values.

Decomposition:
- Package bp_pkg:
  - typedef bp_state_e {INIT, RUN}.
  - struct bp_upd_t {idx[IDX_W-1:0], taken}.
  - Default constants: PHT_IDX_W, GHR_W, PHT_INIT_VAL = 2'b10.
- Sub-module bp_upd_fifo: QDEPTH-entry FIFO with two write ports (ordered), one read port, and occupancy output.
- Top holds the FSM, the GHR/hash logic, and the output registers.

Test Plan (IDX_W=GHR_W=4, QDEPTH=4 for sim):
- Reset release:
  - pht_we=1 and pht_winit=1 with pht_widx 0..15 on 16 consecutive cycles.
  - init_busy falls after index 15; upd_ready=1 the next cycle.
- Single update, ghr=0:
  - Stimulus: lane 0 pc=0x0028 (idx 0xA), taken=1.
  - Response: next cycle pht_we=1, widx=0xA, wtaken=1; ghr becomes 4'b0001.
- Dual update, ghr=4'b0001:
  - Stimulus: lane 0 pc=0x0010 taken=0, lane 1 pc=0x0010 taken=1.
  - Response: widx 0x5 with wtaken=0, then widx 0x6 (0x4 ^ 0b0010) with wtaken=1, on consecutive cycles; ghr = 4'b0101.
- Backpressure:
  - Dual updates on 2 consecutive cycles: second accepted (q_count after: 2→3).
  - Third dual request sees upd_ready=0 until q_count <= 2; no entry lost or reordered.
- reinit with 3 entries queued and a same-cycle valid:
  - No further update writes; ghr=0; walk restarts at index 0.
  - Discarded branch is never written.
- Async reset asserted mid-drain: outputs 0 immediately; full 16-cycle walk repeats after release.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and default constants for the branch-predictor update scheduler
package bp_pkg;
  localparam int PHT_IDX_W = 12;
  localparam int GHR_W = 12;
  localparam logic [1:0] PHT_INIT_VAL = 2'b10;
  typedef enum logic {INIT, RUN} bp_state_e;
  typedef struct packed {
    logic [PHT_IDX_W-1:0] idx;
    logic                 taken;
  } bp_upd_t;
endpackage

// File: rtl/bp_upd_fifo.sv
// bp_upd_fifo: ordered dual-write, single-read FIFO with occupancy count
//   clk, rst      : clock, asynchronous active-low reset
//   flush_i       : drop all entries
//   we0_i/wd0_i   : older write port, lands before port 1 when both fire
//   we1_i/wd1_i   : younger write port
//   re_i/rd_o     : pop request and head entry
//   count_o       : occupancy
// The producer guarantees room for every write it issues.
module bp_upd_fifo #(
  parameter int W = 13,
  parameter int QDEPTH = 4,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          we0_i,
  input  logic [W-1:0]  wd0_i,
  input  logic          we1_i,
  input  logic [W-1:0]  wd1_i,
  input  logic          re_i,
  output logic [W-1:0]  rd_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0] mem_q [QDEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [1:0] nenq;
  assign nenq = {1'b0, we0_i} + {1'b0, we1_i};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_q + PW'(nenq);
      rptr_q <= rptr_q + PW'(re_i);
      cnt_q  <= cnt_q + CW'(nenq) - CW'(re_i);
    end
  end
  // lane 1 takes the slot after lane 0 only when lane 0 also writes
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wptr_q] <= wd0_i;
    if (we1_i) mem_q[we0_i ? wptr_q + PW'(1) : wptr_q] <= wd1_i;
  end
  assign rd_o = mem_q[rptr_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/bp_update_sched.sv
// bp_update_sched: gshare PHT write sequencer and global history owner
//   clk, rst                : clock, asynchronous active-low reset
//   reinit                  : restart the table initialisation walk
//   upd_valid/pc/taken_0/1  : resolved branches, lane 0 older than lane 1
//   upd_ready               : both lanes may transfer this cycle
//   pht_we/widx/wtaken/winit: registered PHT write port
//   ghr                     : committed global history
//   init_busy               : initialisation walk in progress
//   q_count                 : pending update count
module bp_update_sched #(
  parameter int PC_W = 14,
  parameter int IDX_W = 12,
  parameter int GHR_W = 12,
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reinit,
  input  logic             upd_valid_0,
  input  logic [PC_W-1:0]  upd_pc_0,
  input  logic             upd_taken_0,
  input  logic             upd_valid_1,
  input  logic [PC_W-1:0]  upd_pc_1,
  input  logic             upd_taken_1,
  output logic             upd_ready,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_widx,
  output logic             pht_wtaken,
  output logic             pht_winit,
  output logic [GHR_W-1:0] ghr,
  output logic             init_busy,
  output logic [CW-1:0]    q_count
);
  import bp_pkg::*;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;
  bp_state_e state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d, widx_q, widx_d;
  logic [GHR_W-1:0] ghr_q, ghr_d, g1;
  logic we_q, we_d, winit_q, winit_d, wtaken_q, wtaken_d;
  logic run, xfer0, xfer1, deq;
  upd_t e0, e1, head;
  assign run = state_q == RUN;
  // credit only the occupancy at cycle start; a same-cycle pop does not count
  assign upd_ready = run && q_count <= CW'(QDEPTH - 2);
  assign init_busy = !run;
  assign xfer0 = upd_valid_0 && upd_ready && !reinit;
  assign xfer1 = upd_valid_1 && upd_ready && !reinit;
  assign deq = run && q_count != '0 && !reinit;
  // lane 1 hashes against history already shifted by lane 0
  assign g1 = xfer0 ? {ghr_q[GHR_W-2:0], upd_taken_0} : ghr_q;
  assign e0.idx = upd_pc_0[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign e0.taken = upd_taken_0;
  assign e1.idx = upd_pc_1[IDX_W+1:2] ^ IDX_W'(g1);
  assign e1.taken = upd_taken_1;
  bp_upd_fifo #(.W(IDX_W + 1), .QDEPTH(QDEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (reinit),
    .we0_i   (xfer0),
    .wd0_i   (e0),
    .we1_i   (xfer1),
    .wd1_i   (e1),
    .re_i    (deq),
    .rd_o    (head),
    .count_o (q_count)
  );
  always_comb begin
    state_d = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d = xfer1 ? {g1[GHR_W-2:0], upd_taken_1} : g1;
    we_d = 1'b0;
    winit_d = 1'b0;
    wtaken_d = 1'b0;
    widx_d = '0;
    if (reinit) begin
      state_d = INIT;
      init_cnt_d = '0;
      ghr_d = '0;
    end else if (!run) begin
      we_d = 1'b1;
      winit_d = 1'b1;
      widx_d = init_cnt_q;
      init_cnt_d = init_cnt_q + IDX_W'(1);
      state_d = &init_cnt_q ? RUN : INIT;
    end else if (deq) begin
      we_d = 1'b1;
      widx_d = head.idx;
      wtaken_d = head.taken;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
      we_q       <= 1'b0;
      winit_q    <= 1'b0;
      wtaken_q   <= 1'b0;
      widx_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
      we_q       <= we_d;
      winit_q    <= winit_d;
      wtaken_q   <= wtaken_d;
      widx_q     <= widx_d;
    end
  end
  assign pht_we = we_q;
  assign pht_winit = winit_q;
  assign pht_wtaken = wtaken_q;
  assign pht_widx = widx_q;
  assign ghr = ghr_q;
endmodule

// File: tb/tb_bp_update_sched.sv
// tb_bp_update_sched: directed and random checks of bp_update_sched against a queue-based model
module tb_bp_update_sched;
  localparam int PC_W = 14, IDX_W = 4, GHR_W = 4, QDEPTH = 4, CW = 3;
  logic clk = 1'b0, rst = 1'b0, reinit = 1'b0;
  logic upd_valid_0 = 1'b0, upd_taken_0 = 1'b0, upd_valid_1 = 1'b0, upd_taken_1 = 1'b0;
  logic [PC_W-1:0] upd_pc_0 = '0, upd_pc_1 = '0;
  logic upd_ready, pht_we, pht_wtaken, pht_winit, init_busy;
  logic [IDX_W-1:0] pht_widx;
  logic [GHR_W-1:0] ghr;
  logic [CW-1:0] q_count;
  int errors = 0, checks = 0;
  bit m_run;
  int m_cnt, m_ghr, e_we, e_widx, e_wt, e_winit;
  int q[$];

  bp_update_sched #(.PC_W(PC_W), .IDX_W(IDX_W), .GHR_W(GHR_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .reinit(reinit),
    .upd_valid_0(upd_valid_0), .upd_pc_0(upd_pc_0), .upd_taken_0(upd_taken_0),
    .upd_valid_1(upd_valid_1), .upd_pc_1(upd_pc_1), .upd_taken_1(upd_taken_1),
    .upd_ready(upd_ready), .pht_we(pht_we), .pht_widx(pht_widx),
    .pht_wtaken(pht_wtaken), .pht_winit(pht_winit), .ghr(ghr),
    .init_busy(init_busy), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return m_run && (QDEPTH - q.size()) >= 2;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ghr = 0; q.delete();
    e_we = 0; e_widx = 0; e_wt = 0; e_winit = 0;
  endtask

  // one clock edge of the reference behaviour, using the inputs currently driven
  task automatic model_edge();
    bit rdy = m_ready();
    int h, idx;
    if (reinit) begin
      m_run = 0; m_cnt = 0; m_ghr = 0; q.delete(); e_we = 0;
    end else if (!m_run) begin
      e_we = 1; e_winit = 1; e_widx = m_cnt; e_wt = 0;
      if (m_cnt == (1 << IDX_W) - 1) m_run = 1;
      m_cnt = (m_cnt + 1) % (1 << IDX_W);
    end else begin
      if (q.size() > 0) begin
        h = q.pop_front();
        e_we = 1; e_winit = 0; e_widx = h >> 1; e_wt = h & 1;
      end else e_we = 0;
      if (upd_valid_0 && rdy) begin
        idx = ((int'(upd_pc_0) >> 2) & 15) ^ m_ghr;
        q.push_back(idx * 2 + int'(upd_taken_0));
        m_ghr = ((m_ghr << 1) | int'(upd_taken_0)) & 15;
      end
      if (upd_valid_1 && rdy) begin
        idx = ((int'(upd_pc_1) >> 2) & 15) ^ m_ghr;
        q.push_back(idx * 2 + int'(upd_taken_1));
        m_ghr = ((m_ghr << 1) | int'(upd_taken_1)) & 15;
      end
    end
  endtask

  task automatic tick();
    #1;
    chk("upd_ready", upd_ready, m_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pht_we", pht_we, e_we);
    if (e_we != 0) begin
      chk("pht_widx", pht_widx, e_widx);
      chk("pht_wtaken", pht_wtaken, e_wt);
      chk("pht_winit", pht_winit, e_winit);
    end
    chk("ghr", ghr, m_ghr);
    chk("init_busy", init_busy, !m_run);
    chk("q_count", q_count, q.size());
  endtask

  task automatic set_rand_dual();
    upd_valid_0 = 1'b1; upd_valid_1 = 1'b1;
    upd_pc_0 = PC_W'($urandom_range(0, 16383));
    upd_pc_1 = PC_W'($urandom_range(0, 16383));
    upd_taken_0 = 1'($urandom_range(0, 1));
    upd_taken_1 = 1'($urandom_range(0, 1));
  endtask

  task automatic clear_in();
    upd_valid_0 = 1'b0; upd_valid_1 = 1'b0; reinit = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_we", pht_we, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_ready", upd_ready, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_ghr", ghr, 0);
    rst = 1'b1;
    repeat (16) tick();
    chk("walk_done_busy", init_busy, 0);
    chk("walk_done_ready", upd_ready, 1);
    upd_valid_0 = 1'b1; upd_pc_0 = 14'h0028; upd_taken_0 = 1'b1;
    tick();
    clear_in();
    chk("single_ghr", ghr, 4'b0001);
    tick();
    chk("single_we", pht_we, 1);
    chk("single_widx", pht_widx, 4'hA);
    chk("single_wtaken", pht_wtaken, 1);
    upd_valid_0 = 1'b1; upd_pc_0 = 14'h0010; upd_taken_0 = 1'b0;
    upd_valid_1 = 1'b1; upd_pc_1 = 14'h0010; upd_taken_1 = 1'b1;
    tick();
    clear_in();
    chk("dual_ghr", ghr, 4'b0101);
    tick();
    chk("dual0_widx", pht_widx, 4'h5);
    chk("dual0_wtaken", pht_wtaken, 0);
    tick();
    chk("dual1_widx", pht_widx, 4'h6);
    chk("dual1_wtaken", pht_wtaken, 1);
    tick();
    set_rand_dual(); tick();
    set_rand_dual(); tick();
    chk("bp_qcount3", q_count, 3);
    set_rand_dual(); tick();
    chk("bp_qcount2", q_count, 2);
    set_rand_dual(); tick();
    clear_in();
    repeat (5) tick();
    set_rand_dual(); tick();
    set_rand_dual(); tick();
    set_rand_dual(); reinit = 1'b1;
    tick();
    chk("reinit_we", pht_we, 0);
    chk("reinit_ghr", ghr, 0);
    chk("reinit_qcount", q_count, 0);
    chk("reinit_busy", init_busy, 1);
    clear_in();
    tick();
    chk("rewalk_widx", pht_widx, 0);
    chk("rewalk_winit", pht_winit, 1);
    repeat (15) tick();
    repeat (300) begin
      upd_valid_0 = 1'($urandom_range(0, 1));
      upd_valid_1 = 1'($urandom_range(0, 1));
      upd_pc_0 = PC_W'($urandom_range(0, 16383));
      upd_pc_1 = PC_W'($urandom_range(0, 16383));
      upd_taken_0 = 1'($urandom_range(0, 1));
      upd_taken_1 = 1'($urandom_range(0, 1));
      reinit = ($urandom_range(0, 59) == 0);
      tick();
    end
    clear_in();
    repeat (20) tick();
    set_rand_dual(); tick();
    set_rand_dual(); tick();
    clear_in();
    #2 rst = 1'b0;
    #1;
    chk("arst_we", pht_we, 0);
    chk("arst_busy", init_busy, 1);
    chk("arst_ready", upd_ready, 0);
    chk("arst_qcount", q_count, 0);
    chk("arst_ghr", ghr, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (16) tick();
    chk("arst_walk_done", init_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
